// File: rtl/td4_prog_loader_if.sv
// -----------------------------------------------------------------------------
// td4_prog_loader_if
//
// Purpose: bundles the signals between the program loader, the byte source
// that feeds it, and the TD4 CPU core it holds in reset.
//
// Signals:
//   ld_start   load request; begins or restarts a program load
//   ld_valid   loader byte valid
//   ld_data    loader byte (opcode[7:4], immediate[3:0])
//   ld_ready   loader accepts a byte this cycle
//   addr_rom   program address from the CPU core
//   data_rom   instruction word returned to the CPU core
//   cpu_clr_n  active-low reset to the CPU core
//   ld_done    a valid program is loaded and the CPU is running
//   ld_err     checksum failure flag
//
// Modports:
//   master  byte source / CPU side (drives requests, bytes and addresses)
//   slave   the loader itself
//
// Handshake: a byte transfers on a rising clk edge where ld_valid and
// ld_ready are both 1 and ld_start is 0. ld_ready does not depend on
// ld_valid; ld_start always wins and the byte offered in that cycle is
// dropped.
// -----------------------------------------------------------------------------
interface td4_prog_loader_if;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [3:0] addr_rom;
    logic [7:0] data_rom;
    logic       cpu_clr_n;
    logic       ld_done;
    logic       ld_err;

    modport master (
        output ld_start,
        output ld_valid,
        output ld_data,
        output addr_rom,
        input  ld_ready,
        input  data_rom,
        input  cpu_clr_n,
        input  ld_done,
        input  ld_err
    );

    modport slave (
        input  ld_start,
        input  ld_valid,
        input  ld_data,
        input  addr_rom,
        output ld_ready,
        output data_rom,
        output cpu_clr_n,
        output ld_done,
        output ld_err
    );
endinterface

// File: rtl/td4_prog_loader.sv
// -----------------------------------------------------------------------------
// td4_prog_loader
//
// Purpose: receives a 16-byte program over a valid/ready byte stream, stores
// it in a 16 x 8 program memory that the TD4 core reads combinationally, and
// holds the core in reset until the load completes plus RELEASE_DELAY cycles.
//
// Optional feature (macro TD4_PROG_CHECKSUM_EN):
//   defined   - after the 16 program bytes one extra checksum byte is accepted
//               (not stored); the 8-bit sum of all 17 bytes must be 8'h00,
//               otherwise the block parks in ERROR with ld_err=1.
//   undefined - a load is exactly 16 bytes, ld_err is constant 0.
//
// Parameters:
//   RELEASE_DELAY  cycles cpu_clr_n stays low after the last byte (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   clr_n        asynchronous active-low reset
//   bus          td4_prog_loader_if.slave (loader stream + ROM port + status)
//   dbg_state_o  current FSM state encoding, for observation only
//
// Handshake: a byte transfers on a rising clk edge where ld_valid and
// ld_ready are both 1 and ld_start is 0. ld_ready is registered and does not
// depend on ld_valid; ld_start has priority and drops a simultaneous byte.
// -----------------------------------------------------------------------------
module td4_prog_loader #(
    parameter int unsigned RELEASE_DELAY = 3
) (
    input  logic                clk,
    input  logic                clr_n,
    td4_prog_loader_if.slave    bus,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3
`ifdef TD4_PROG_CHECKSUM_EN
        ,
        ST_CHECK   = 3'd4,
        ST_ERROR   = 3'd5
`endif
    } state_e;

    localparam logic [3:0] DELAY_INIT = 4'(RELEASE_DELAY);

    state_e     state_q;
    logic [3:0] wp_q;
    logic [3:0] cnt_q;
    logic [7:0] mem_q [16];
    logic       cpu_clr_n_q;
    logic       ld_ready_q;
    logic       ld_done_q;

    logic       accept;
    logic [3:0] wp_d;
    logic [3:0] cnt_d;

`ifdef TD4_PROG_CHECKSUM_EN
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic       ld_err_q;
`endif

    // A byte is taken only while ld_ready is up and no restart is requested.
    always_comb begin
        accept = bus.ld_valid && ld_ready_q && !bus.ld_start;
        wp_d   = wp_q + 4'd1;
        cnt_d  = cnt_q - 4'd1;
`ifdef TD4_PROG_CHECKSUM_EN
        acc_d  = acc_q + bus.ld_data;
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            wp_q        <= 4'd0;
            cnt_q       <= 4'd0;
            cpu_clr_n_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
`ifdef TD4_PROG_CHECKSUM_EN
            acc_q       <= 8'h00;
            ld_err_q    <= 1'b0;
`endif
        end else if (bus.ld_start) begin
            // Restart from any state: the core goes back into reset and the
            // write pointer rewinds so no byte of an earlier load survives
            // past the ones the new load overwrites.
            state_q     <= ST_LOAD;
            wp_q        <= 4'd0;
            cnt_q       <= 4'd0;
            cpu_clr_n_q <= 1'b0;
            ld_ready_q  <= 1'b1;
            ld_done_q   <= 1'b0;
`ifdef TD4_PROG_CHECKSUM_EN
            acc_q       <= 8'h00;
            ld_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_clr_n_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    ld_done_q   <= 1'b0;
                end

                ST_LOAD: begin
                    if (accept) begin
                        mem_q[wp_q] <= bus.ld_data;
                        wp_q        <= wp_d;
`ifdef TD4_PROG_CHECKSUM_EN
                        acc_q       <= acc_d;
`endif
                        // The 16th byte leaves LOAD, so the pointer wrapping
                        // to 0 here can never produce a 17th write.
                        if (wp_q == 4'd15) begin
`ifdef TD4_PROG_CHECKSUM_EN
                            state_q    <= ST_CHECK;
                            ld_ready_q <= 1'b1;
`else
                            state_q    <= ST_RELEASE;
                            ld_ready_q <= 1'b0;
                            cnt_q      <= DELAY_INIT;
`endif
                        end
                    end
                end

`ifdef TD4_PROG_CHECKSUM_EN
                ST_CHECK: begin
                    // Checksum byte is summed but not stored.
                    if (accept) begin
                        acc_q      <= acc_d;
                        ld_ready_q <= 1'b0;
                        if (acc_d == 8'h00) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= DELAY_INIT;
                        end else begin
                            state_q  <= ST_ERROR;
                            ld_err_q <= 1'b1;
                        end
                    end
                end

                ST_ERROR: begin
                    cpu_clr_n_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    ld_done_q   <= 1'b0;
                    ld_err_q    <= 1'b1;
                end
`endif

                ST_RELEASE: begin
                    // cnt_q == 1 is the last low cycle; cpu_clr_n rises on the
                    // same edge that enters RUN, straight from this flop.
                    if (cnt_q == 4'd1) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= 4'd0;
                        cpu_clr_n_q <= 1'b1;
                        ld_done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_RUN: begin
                    cpu_clr_n_q <= 1'b1;
                    ld_done_q   <= 1'b1;
                    ld_ready_q  <= 1'b0;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cpu_clr_n_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    ld_done_q   <= 1'b0;
                end
            endcase
        end
    end

    // Program memory read is combinational so the core sees its instruction
    // in the same cycle it presents the address.
    assign bus.data_rom  = mem_q[bus.addr_rom];
    assign bus.cpu_clr_n = cpu_clr_n_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_done   = ld_done_q;
`ifdef TD4_PROG_CHECKSUM_EN
    assign bus.ld_err    = ld_err_q;
`else
    assign bus.ld_err    = 1'b0;
`endif
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
module tb_td4_prog_loader;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] vec[16];

  td4_prog_loader_if bus();

  td4_prog_loader #(.RELEASE_DELAY(3)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_load();
    bus.ld_start = 1'b1;
    @(negedge clk);
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 20 && bus.ld_ready !== 1'b1; i++) @(negedge clk);
    total++;
    if (bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: ld_ready=%b required=1", bus.ld_ready);
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'hFF;
  endtask

  task automatic send_vec(input bit gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(vec[i]);
      exp_q.push_back(vec[i]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && bus.ld_done !== 1'b1; i++) @(negedge clk);
    total++;
    if (bus.ld_done !== 1'b1) begin
      bad++;
      $display("FAIL wait_run: ld_done=%b required=1 (timeout)", bus.ld_done);
    end
  endtask

  // scoreboard: reads every address and compares with the expected queue
  task automatic check_mem(input string name);
    logic [7:0] e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.addr_rom = 4'(i);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.data_rom !== e) begin
        bad++;
        $display("FAIL %s mem[%0d]: data_rom=%h required=%h", name, i, bus.data_rom, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_zeros();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state: %0d required=%0d", dbg_state, S_IDLE); end
    total++;
    if (bus.cpu_clr_n !== 1'b0) begin bad++; $display("FAIL reset_cpu_clr_n: %b required=0", bus.cpu_clr_n); end
    total++;
    if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: %b required=0", bus.ld_ready); end
    total++;
    if (bus.ld_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done: %b required=0", bus.ld_done); end
    total++;
    if (bus.ld_err !== 1'b0) begin bad++; $display("FAIL reset_ld_err: %b required=0", bus.ld_err); end
    // ld_valid while IDLE must not write
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h55;
    repeat (3) @(negedge clk);
    idle_inputs();
    total++;
    if (dbg_state !== S_IDLE) begin bad++; $display("FAIL idle_valid_state: %0d required=%0d", dbg_state, S_IDLE); end
    push_zeros();
    check_mem("reset");
  endtask

  task automatic test_basic_load();
    vec[0] = 8'h20; vec[1] = 8'h02; vec[2] = 8'h40; vec[3] = 8'h90;
    for (int i = 4; i < 16; i++) vec[i] = 8'h00;
    start_load();
    total++;
    if (dbg_state !== S_LOAD) begin bad++; $display("FAIL basic_enter_load: state=%0d required=%0d", dbg_state, S_LOAD); end
    total++;
    if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: %b required=1", bus.ld_ready); end
    send_vec(1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.cpu_clr_n !== 1'b0 || bus.ld_done !== 1'b0) begin
        bad++;
        $display("FAIL basic_release_cycle%0d: cpu_clr_n=%b ld_done=%b required=0/0", k, bus.cpu_clr_n, bus.ld_done);
      end
      @(negedge clk);
    end
    total++;
    if (bus.cpu_clr_n !== 1'b1 || bus.ld_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_run: cpu_clr_n=%b ld_done=%b required=1/1", bus.cpu_clr_n, bus.ld_done);
    end
    total++;
    if (dbg_state !== S_RUN || bus.ld_ready !== 1'b0 || bus.ld_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_run_flags: state=%0d ready=%b err=%b required=%0d/0/0", dbg_state, bus.ld_ready, bus.ld_err, S_RUN);
    end
    bus.addr_rom = 4'h3;
    #1;
    total++;
    if (bus.data_rom !== 8'h90) begin bad++; $display("FAIL basic_addr3: data_rom=%h required=90", bus.data_rom); end
    check_mem("basic");
  endtask

  task automatic test_ignore_valid();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h77;
    repeat (4) @(negedge clk);
    idle_inputs();
    total++;
    if (dbg_state !== S_RUN || bus.ld_done !== 1'b1) begin
      bad++;
      $display("FAIL ignore_state: state=%0d done=%b required=%0d/1", dbg_state, bus.ld_done, S_RUN);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(vec[i]);
    check_mem("ignore");
  endtask

  task automatic test_toggle_valid();
    do_reset();
    start_load();
    send_vec(1'b1);
    wait_run();
    check_mem("toggle");
  endtask

  task automatic test_restart();
    start_load();
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
    start_load();
    total++;
    if (dbg_state !== S_LOAD || bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL restart_load: state=%0d ready=%b required=%0d/1", dbg_state, bus.ld_ready, S_LOAD);
    end
    for (int i = 0; i < 16; i++) vec[i] = 8'hB0 + 8'(i);
    send_vec(1'b0);
    wait_run();
    check_mem("restart");
  endtask

  task automatic test_start_collision();
    start_load();
    for (int i = 0; i < 15; i++) send_byte(8'h60 + 8'(i));
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hEE;
    bus.ld_start = 1'b1;
    @(negedge clk);
    idle_inputs();
    total++;
    if (dbg_state !== S_LOAD || bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL collide_state: state=%0d ready=%b required=%0d/1", dbg_state, bus.ld_ready, S_LOAD);
    end
    total++;
    if (bus.cpu_clr_n !== 1'b0 || bus.ld_done !== 1'b0) begin
      bad++;
      $display("FAIL collide_outputs: cpu_clr_n=%b done=%b required=0/0", bus.cpu_clr_n, bus.ld_done);
    end
    repeat (4) @(negedge clk);
    total++;
    if (dbg_state !== S_LOAD) begin bad++; $display("FAIL collide_no_release: state=%0d required=%0d", dbg_state, S_LOAD); end
    for (int i = 0; i < 16; i++) vec[i] = 8'hC0 + 8'(i);
    send_vec(1'b0);
    wait_run();
    check_mem("collide");
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dbg_state !== S_IDLE || bus.ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL midload_idle: state=%0d ready=%b required=%0d/0", dbg_state, bus.ld_ready, S_IDLE);
    end
    push_zeros();
    check_mem("midload");
  endtask

  task automatic test_reset_in_run();
    start_load();
    for (int i = 0; i < 16; i++) vec[i] = 8'h11 + 8'(i);
    send_vec(1'b0);
    wait_run();
    exp_q.delete();
    clr_n = 1'b0;
    #1;
    total++;
    if (bus.cpu_clr_n !== 1'b0 || bus.ld_done !== 1'b0) begin
      bad++;
      $display("FAIL runreset_outputs: cpu_clr_n=%b done=%b required=0/0", bus.cpu_clr_n, bus.ld_done);
    end
    for (int i = 0; i < 16; i++) begin
      bus.addr_rom = 4'(i);
      #1;
      total++;
      if (bus.data_rom !== 8'h00) begin
        bad++;
        $display("FAIL runreset_mem[%0d]: data_rom=%h required=00", i, bus.data_rom);
      end
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef TD4_PROG_CHECKSUM_EN
  task automatic test_checksum();
    vec[0] = 8'h20; vec[1] = 8'h02; vec[2] = 8'h40; vec[3] = 8'h90;
    for (int i = 4; i < 16; i++) vec[i] = 8'h00;
    start_load();
    send_vec(1'b0);
    total++;
    if (dbg_state !== S_CHECK || bus.ld_ready !== 1'b1 || bus.cpu_clr_n !== 1'b0) begin
      bad++;
      $display("FAIL cks_check: state=%0d ready=%b clr=%b required=%0d/1/0", dbg_state, bus.ld_ready, bus.cpu_clr_n, S_CHECK);
    end
    send_byte(8'h0E);
    total++;
    if (dbg_state !== S_RELEASE) begin bad++; $display("FAIL cks_release: state=%0d required=%0d", dbg_state, S_RELEASE); end
    wait_run();
    total++;
    if (bus.ld_err !== 1'b0) begin bad++; $display("FAIL cks_good_err: %b required=0", bus.ld_err); end
    check_mem("cks_good");
    start_load();
    send_vec(1'b0);
    send_byte(8'h0F);
    total++;
    if (dbg_state !== S_ERROR || bus.ld_err !== 1'b1 || bus.cpu_clr_n !== 1'b0 || bus.ld_done !== 1'b0) begin
      bad++;
      $display("FAIL cks_bad: state=%0d err=%b clr=%b done=%b required=%0d/1/0/0", dbg_state, bus.ld_err, bus.cpu_clr_n, bus.ld_done, S_ERROR);
    end
    repeat (3) @(negedge clk);
    total++;
    if (dbg_state !== S_ERROR || bus.ld_err !== 1'b1) begin
      bad++;
      $display("FAIL cks_hold: state=%0d err=%b required=%0d/1", dbg_state, bus.ld_err, S_ERROR);
    end
    check_mem("cks_bad");
    start_load();
    total++;
    if (bus.ld_err !== 1'b0 || dbg_state !== S_LOAD) begin
      bad++;
      $display("FAIL cks_clear: err=%b state=%0d required=0/%0d", bus.ld_err, dbg_state, S_LOAD);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    clr_n = 1'b0;
    idle_inputs();
    bus.addr_rom = 4'h0;
    do_reset();
    test_reset();
    test_basic_load();
    test_ignore_valid();
    test_toggle_valid();
    test_restart();
    test_start_collision();
    test_reset_mid_load();
    test_reset_in_run();
`ifdef TD4_PROG_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
